digi_readout_framer: RTL and testbench

Downstream stage of the multi-channel digitizer. Consumes the 16-bit channel-serialised sample stream produced while `ZYNQ_RD_EN` is high, buffers it in a synchronous FIFO, and emits one framed event per readout (header, data, trailer) over a valid/ready word interface to the SPI link to the ZYNQ. Returns a one-cycle `SPI_done` pulse to the digitizer when the frame trailer has been accepted.

---
 rtl/digi_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/digi_readout_framer.sv | 183 ++++++++++++++++++
 tb/tb_digi_readout_framer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digi_pkg.sv
// Shared definitions for the digitizer readout framer: FSM states, defaults,
// header word positions and the word-count saturation helper.
package digi_pkg;

  localparam int unsigned FIFO_AW_DEF   = 9;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hCAFE;
  localparam logic [14:0] WCOUNT_MAX    = 15'h7FFF;

  // Framer states; the state names the word currently held in the output register.
  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    DATA,
    TRL0,
    TRL1,
    DONE
  } state_e;

  // Word positions inside a frame (header first, then data, then trailer).
  typedef enum int unsigned {
    W_SYNC       = 0,
    W_EVENT      = 1,
    W_NSAMP      = 2,
    W_FIRST_DATA = 3
  } word_idx_e;

  // Per-frame written-word counter, sticks at its maximum instead of wrapping.
  function automatic logic [14:0] sat_inc15(input logic [14:0] v);
    return (v == WCOUNT_MAX) ? v : v + 15'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count. Full/empty come from the
// registered count, so a write while full is dropped even if a pop happens in
// the same cycle, and a word written into an empty FIFO is visible next cycle.
module sync_fifo #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH      = 2 ** AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  // Status flags, qualified strobes and head-of-queue read.
  always_comb begin
    full    = (count == FULL_COUNT);
    empty   = (count == '0);
    wr_ok   = wr_en && !full;
    rd_ok   = rd_en && !empty;
    rd_data = mem[rd_ptr];
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/digi_readout_framer.sv
// Frames one digitizer readout window into header / data / trailer words on a
// valid/ready link towards the SPI bridge and pulses SPI_done at the end.
module digi_readout_framer
  import digi_pkg::*;
#(
  parameter int unsigned FIFO_AW   = FIFO_AW_DEF,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic        SYSCLK,
  input  logic        RST,
  input  logic        ZYNQ_RD_EN,
  input  logic [15:0] DIN,
  input  logic        DIN_VALID,
  input  logic [11:0] ADC_sample_num,
  output logic [15:0] TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        SPI_done,
  output logic        OVERFLOW
);

  state_e      state;
  logic        rd_en_q;
  logic        start_q;
  logic [11:0] num_q;
  logic [15:0] evt_cnt;
  logic [14:0] wcount;
  logic [15:0] csum;
  logic        ovf;

  logic        capture;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [15:0] fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        xfer;
  logic        start;
  logic        data_load;
  logic        data_exit;

  sync_fifo #(
    .W  (16),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (SYSCLK),
    .rst     (RST),
    .wr_en   (fifo_wr),
    .wr_data (DIN),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Capture window, handshake and output-register refill decisions.
  always_comb begin
    capture   = (state == HDR0) || (state == HDR1) || (state == HDR2) || (state == DATA);
    fifo_wr   = capture && DIN_VALID;
    xfer      = TX_VALID && TX_READY;
    start     = (state == IDLE) && start_q;
    data_load = (state == DATA) && (!TX_VALID || TX_READY);
    fifo_rd   = data_load && !fifo_empty;
    // A write landing on the exit edge would be stranded in the FIFO, so the
    // data phase only closes once the input is also quiet.
    data_exit = (state == DATA) && !ZYNQ_RD_EN && fifo_empty && !TX_VALID && !DIN_VALID;
  end

  // Registered rising-edge detector for the readout window, armed only in IDLE.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      rd_en_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      rd_en_q <= ZYNQ_RD_EN;
      start_q <= ZYNQ_RD_EN && !rd_en_q && (state == IDLE);
    end
  end

  // Per-frame accumulators, sample count latch and sticky overflow flag.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      num_q    <= '0;
      wcount   <= '0;
      csum     <= '0;
      ovf      <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (start) begin
      num_q  <= ADC_sample_num;
      wcount <= '0;
      csum   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (fifo_wr) begin
        if (fifo_full) begin
          ovf      <= 1'b1;
          OVERFLOW <= 1'b1;
        end else begin
          wcount <= sat_inc15(wcount);
        end
      end
      if ((state == DATA) && xfer) begin
        csum <= csum ^ TX_DATA;
      end
    end
  end

  // Framer FSM driving the registered output word, valid and done pulse.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      SPI_done <= 1'b0;
      evt_cnt  <= '0;
    end else begin
      SPI_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR0;
            TX_DATA  <= SYNC_WORD;
            TX_VALID <= 1'b1;
          end
        end
        HDR0: begin
          if (xfer) begin
            state   <= HDR1;
            TX_DATA <= evt_cnt;
          end
        end
        HDR1: begin
          if (xfer) begin
            state   <= HDR2;
            TX_DATA <= {4'h0, num_q};
          end
        end
        HDR2: begin
          if (xfer) begin
            state    <= DATA;
            TX_VALID <= 1'b0;
          end
        end
        DATA: begin
          if (data_exit) begin
            state    <= TRL0;
            TX_DATA  <= {ovf, wcount};
            TX_VALID <= 1'b1;
          end else if (data_load) begin
            // The output register acts as the FIFO head stage: refill on
            // every accepted word so a steady TX_READY sees no bubbles.
            TX_VALID <= !fifo_empty;
            if (!fifo_empty) begin
              TX_DATA <= fifo_rd_data;
            end
          end
        end
        TRL0: begin
          if (xfer) begin
            state   <= TRL1;
            TX_DATA <= csum;
          end
        end
        TRL1: begin
          if (xfer) begin
            state    <= DONE;
            TX_VALID <= 1'b0;
            SPI_done <= 1'b1;
          end
        end
        DONE: begin
          evt_cnt <= evt_cnt + 16'd1;
          state   <= IDLE;
        end
        default: begin
          state    <= IDLE;
          TX_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digi_readout_framer.sv
// Directed bench for digi_readout_framer: frame content, backpressure,
// overflow (small FIFO instance), event counter, mid-frame reset, stray input.
module tb_digi_readout_framer;
  import digi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [11:0] sample_num = '0;
  logic        tx_ready = 1'b0;

  logic [15:0] tx_data, s_tx_data;
  logic        tx_valid, s_tx_valid;
  logic        spi_done, s_spi_done;
  logic        overflow, s_overflow;

  always #5 clk = ~clk;

  digi_readout_framer #(.FIFO_AW(9), .SYNC_WORD(16'hCAFE)) dut (
    .SYSCLK(clk), .RST(rst), .ZYNQ_RD_EN(rd_en), .DIN(din), .DIN_VALID(din_valid),
    .ADC_sample_num(sample_num), .TX_DATA(tx_data), .TX_VALID(tx_valid),
    .TX_READY(tx_ready), .SPI_done(spi_done), .OVERFLOW(overflow)
  );

  digi_readout_framer #(.FIFO_AW(2), .SYNC_WORD(16'hCAFE)) dut_s (
    .SYSCLK(clk), .RST(rst), .ZYNQ_RD_EN(rd_en), .DIN(din), .DIN_VALID(din_valid),
    .ADC_sample_num(sample_num), .TX_DATA(s_tx_data), .TX_VALID(s_tx_valid),
    .TX_READY(tx_ready), .SPI_done(s_spi_done), .OVERFLOW(s_overflow)
  );

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;
  int stall_cnt = 0;
  int stall_viol = 0;
  int rmode = 0;
  int cyc = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0] got[$];
  logic [15:0] s_got[$];
  logic [15:0] vec [16];

  // Transfer recorder and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (s_tx_valid && tx_ready) s_got.push_back(s_tx_data);
      if (spi_done) done_cnt++;
      if (s_spi_done) s_done_cnt++;
      if (prev_stall) begin
        stall_cnt++;
        if (!(tx_valid && tx_data == prev_data)) stall_viol++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc % 3) == 0);
      default: tx_ready = !rd_en;
    endcase
  endtask

  task automatic do_reset;
    rst = 1'b1;
    rd_en = 1'b0;
    din_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    got.delete();
    s_got.delete();
  endtask

  // One readout window carrying vec[0..nw-1]; waits for both instances to finish.
  task automatic readout(input logic [11:0] num, input int nw, output int lat);
    int d0, sd0, k;
    d0 = done_cnt;
    sd0 = s_done_cnt;
    sample_num = num;
    rd_en = 1'b1;
    lat = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (lat == 0 && tx_valid) lat = i + 1;
    end
    for (int i = 0; i < nw; i++) begin
      din = vec[i];
      din_valid = 1'b1;
      tick;
    end
    din_valid = 1'b0;
    rd_en = 1'b0;
    k = 0;
    while ((done_cnt == d0 || s_done_cnt == sd0) && k < 400) begin
      tick;
      k++;
    end
    checks++;
    if (k >= 400) begin
      fails++;
      $display("FAIL readout_timeout got %0d cycles exp <400", k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks += 4;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    if (tx_data !== 16'h0000) begin fails++; $display("FAIL rst_tx_data got %h exp 0000", tx_data); end
    if (spi_done !== 1'b0) begin fails++; $display("FAIL rst_spi_done got %b exp 0", spi_done); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    do_reset;
    checks += 4;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL post_rst_tx_valid got %b exp 0", tx_valid); end
    if (tx_data !== 16'h0000) begin fails++; $display("FAIL post_rst_tx_data got %h exp 0000", tx_data); end
    if (s_tx_valid !== 1'b0) begin fails++; $display("FAIL post_rst_s_tx_valid got %b exp 0", s_tx_valid); end
    if (s_overflow !== 1'b0) begin fails++; $display("FAIL post_rst_s_overflow got %b exp 0", s_overflow); end
  endtask

  task automatic test_basic_frame;
    logic [15:0] exp [13] = '{16'hCAFE, 16'h0000, 16'h0004,
                              16'h0010, 16'h0020, 16'h0030, 16'h0040,
                              16'h0050, 16'h0060, 16'h0070, 16'h0080,
                              16'h0008, 16'h0080};
    int lat, d0;
    logic [15:0] act;
    do_reset;
    rmode = 0;
    for (int i = 0; i < 8; i++) vec[i] = 16'((i + 1) * 16);
    d0 = done_cnt;
    readout(12'd4, 8, lat);
    tick; tick; tick;
    checks++;
    if (lat != 2) begin fails++; $display("FAIL basic_hdr_latency got %0d exp 2", lat); end
    checks++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - d0); end
    checks++;
    if (got.size() != 13) begin fails++; $display("FAIL basic_len got %0d exp 13", got.size()); end
    for (int i = 0; i < 13; i++) begin
      act = (i < got.size()) ? got[i] : 16'hxxxx;
      checks++;
      if (act !== exp[i]) begin fails++; $display("FAIL basic_word[%0d] got %h exp %h", i, act, exp[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp [13] = '{16'hCAFE, 16'h0000, 16'h0008,
                              16'h1230, 16'h4560, 16'h7890, 16'hABC0,
                              16'hDEF0, 16'h0FF0, 16'h5550, 16'hAAA0,
                              16'h0008, 16'hAAF0};
    int lat;
    logic [15:0] act;
    do_reset;
    rmode = 1;
    stall_cnt = 0;
    stall_viol = 0;
    for (int i = 0; i < 8; i++) vec[i] = exp[3 + i];
    readout(12'd8, 8, lat);
    checks++;
    if (got.size() != 13) begin fails++; $display("FAIL bp_len got %0d exp 13", got.size()); end
    for (int i = 0; i < 13; i++) begin
      act = (i < got.size()) ? got[i] : 16'hxxxx;
      checks++;
      if (act !== exp[i]) begin fails++; $display("FAIL bp_word[%0d] got %h exp %h", i, act, exp[i]); end
    end
    checks++;
    if (stall_cnt == 0) begin fails++; $display("FAIL bp_stall_seen got %0d exp >0", stall_cnt); end
    checks++;
    if (stall_viol != 0) begin fails++; $display("FAIL bp_stall_stable got %0d exp 0", stall_viol); end
    rmode = 0;
  endtask

  task automatic test_overflow;
    logic [15:0] exp [9] = '{16'hCAFE, 16'h0000, 16'h000A,
                             16'h0100, 16'h0200, 16'h0300, 16'h0400,
                             16'h8004, 16'h0400};
    int lat;
    logic [15:0] act;
    do_reset;
    rmode = 2;
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) vec[i] = 16'((i + 1) * 256);
    readout(12'd10, 10, lat);
    checks++;
    if (s_got.size() != 9) begin fails++; $display("FAIL ovf_len got %0d exp 9", s_got.size()); end
    for (int i = 0; i < 9; i++) begin
      act = (i < s_got.size()) ? s_got[i] : 16'hxxxx;
      checks++;
      if (act !== exp[i]) begin fails++; $display("FAIL ovf_word[%0d] got %h exp %h", i, act, exp[i]); end
    end
    checks++;
    if (s_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", s_overflow); end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_deep_fifo_flag got %b exp 0", overflow); end
    rmode = 0;
  endtask

  task automatic test_event_counter;
    int lat;
    do_reset;
    rmode = 0;
    vec[0] = 16'h0050;
    for (int f = 0; f < 3; f++) readout(12'd1, 1, lat);
    checks++;
    if (got.size() != 18) begin fails++; $display("FAIL evt_len got %0d exp 18", got.size()); end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (got.size() != 18 || got[f * 6 + W_EVENT] !== 16'(f)) begin
        fails++;
        $display("FAIL evt_hdr1[%0d] got %h exp %h", f, (got.size() == 18) ? got[f * 6 + W_EVENT] : 16'hxxxx, 16'(f));
      end
    end
    tick;
    force dut.evt_cnt = 16'hFFFF;
    tick;
    release dut.evt_cnt;
    got.delete();
    readout(12'd1, 1, lat);
    readout(12'd1, 1, lat);
    checks++;
    if (got.size() != 12 || got[W_EVENT] !== 16'hFFFF) begin
      fails++;
      $display("FAIL evt_preload got %h exp ffff", (got.size() == 12) ? got[W_EVENT] : 16'hxxxx);
    end
    checks++;
    if (got.size() != 12 || got[6 + W_EVENT] !== 16'h0000) begin
      fails++;
      $display("FAIL evt_wrap got %h exp 0000", (got.size() == 12) ? got[6 + W_EVENT] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] exp [7] = '{16'hCAFE, 16'h0000, 16'h0002,
                             16'h0770, 16'h0880, 16'h0002, 16'h0FF0};
    int lat, d0, k;
    logic [15:0] act;
    do_reset;
    rmode = 0;
    d0 = done_cnt;
    sample_num = 12'd6;
    rd_en = 1'b1;
    tick;
    tick;
    for (int i = 0; i < 6; i++) begin
      din = 16'((i + 1) * 256);
      din_valid = 1'b1;
      tick;
    end
    din_valid = 1'b0;
    k = 0;
    while (got.size() < 6 && k < 50) begin
      tick;
      k++;
    end
    rst = 1'b1;
    rd_en = 1'b0;
    #1;
    checks += 2;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_tx_valid got %b exp 0", tx_valid); end
    if (spi_done !== 1'b0) begin fails++; $display("FAIL rstmid_spi_done got %b exp 0", spi_done); end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    checks += 3;
    if (done_cnt != d0) begin fails++; $display("FAIL rstmid_no_done got %0d exp %0d", done_cnt, d0); end
    if (got.size() != 6) begin fails++; $display("FAIL rstmid_len got %0d exp 6", got.size()); end
    if (got.size() < 6 || got[5] !== 16'h0300) begin
      fails++;
      $display("FAIL rstmid_last_word got %h exp 0300", (got.size() >= 6) ? got[5] : 16'hxxxx);
    end
    got.delete();
    vec[0] = 16'h0770;
    vec[1] = 16'h0880;
    readout(12'd2, 2, lat);
    checks++;
    if (got.size() != 7) begin fails++; $display("FAIL rstmid_next_len got %0d exp 7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 16'hxxxx;
      checks++;
      if (act !== exp[i]) begin fails++; $display("FAIL rstmid_next_word[%0d] got %h exp %h", i, act, exp[i]); end
    end
  endtask

  task automatic test_stray_input;
    logic [15:0] exp [7] = '{16'hCAFE, 16'h0000, 16'h0002,
                             16'h0110, 16'h0220, 16'h0002, 16'h0330};
    int d0, k;
    logic [15:0] act;
    do_reset;
    rmode = 0;
    d0 = done_cnt;
    din = 16'hBAD0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    din_valid = 1'b0;
    sample_num = 12'd2;
    rd_en = 1'b1;
    tick;
    tick;
    din = 16'h0110; din_valid = 1'b1; tick;
    din = 16'h0220; tick;
    din_valid = 1'b0;
    rd_en = 1'b0;
    k = 0;
    while (!(tx_valid && got.size() == 5) && k < 50) begin
      tick;
      k++;
    end
    checks++;
    if (k >= 50) begin fails++; $display("FAIL stray_trl0_timeout got %0d cycles exp <50", k); end
    din = 16'hDEA0;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 50) begin
      tick;
      k++;
    end
    checks++;
    if (k >= 50) begin fails++; $display("FAIL stray_done_timeout got %0d cycles exp <50", k); end
    checks++;
    if (got.size() != 7) begin fails++; $display("FAIL stray_len got %0d exp 7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 16'hxxxx;
      checks++;
      if (act !== exp[i]) begin fails++; $display("FAIL stray_word[%0d] got %h exp %h", i, act, exp[i]); end
    end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL stray_overflow got %b exp 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_backpressure;
    test_overflow;
    test_event_counter;
    test_reset_mid_frame;
    test_stray_input;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
